// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD down-counter.
// Counts a loaded value down to zero, holds at zero for HOLD cycles with a
// one-cycle terminal-count pulse, then parks idle or reloads.
// Optional feature macro: BCD_DCNT_AUTO_RELOAD_EN (defined: periodic reload
// after the hold window; undefined: one-shot, parks in IDLE after the hold).
module bcd_down_counter #(
    parameter int DIGITS = 2,
    parameter int HOLD   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                holding,
    output logic                tc
);

    localparam int CW = 4 * DIGITS;
    localparam int TW = $clog2(HOLD + 1);
    localparam logic [TW-1:0] HOLD_INIT = TW'(HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] reload_q, reload_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tc_q, tc_d;
    logic [CW-1:0] load_clamped;

    // Saturate every nibble above 9 to 9 so the counter only ever holds BCD.
    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Decimal decrement: a zero digit wraps to 9 and borrows from the next one.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign load_clamped = bcd_clamp(load_val);

    // Next-state logic: load wins over everything, then per-state behaviour.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        timer_d  = timer_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_clamped;
            reload_d = load_clamped;
            if (load_clamped == '0) begin
                state_d = S_HOLD;
                timer_d = HOLD_INIT;
                tc_d    = 1'b1;
            end else begin
                state_d = S_COUNT;
            end
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (en) begin
                        // Count of 1 (or an unexpected 0) is terminal: never underflow.
                        if (count_q <= CW'(1)) begin
                            count_d = '0;
                            state_d = S_HOLD;
                            timer_d = HOLD_INIT;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = bcd_dec(count_q);
                        end
                    end
                end
                S_HOLD: begin
                    if (timer_q <= TW'(1)) begin
`ifdef BCD_DCNT_AUTO_RELOAD_EN
                        count_d = reload_q;
                        if (reload_q == '0) begin
                            state_d = S_HOLD;
                            timer_d = HOLD_INIT;
                            tc_d    = 1'b1;
                        end else begin
                            state_d = S_COUNT;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    // IDLE: hold count, ignore en.
                end
            endcase
        end
    end

`ifndef BCD_DCNT_AUTO_RELOAD_EN
    // The reload register is still written on load but has no reader in the one-shot build.
    logic unused_reload;
    assign unused_reload = ^reload_q;
`endif

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            timer_q  <= '0;
            tc_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            timer_q  <= timer_d;
            tc_q     <= tc_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q != S_IDLE);
    assign holding = (state_q == S_HOLD);
    assign tc      = tc_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed test-plan scenarios plus randomized stimulus,
// checked against a decimal-arithmetic reference model of the counter.
// Honours BCD_DCNT_AUTO_RELOAD_EN the same way the design does.
module tb_bcd_down_counter;

    localparam int DIGITS = 2;
    localparam int HOLD   = 3;
    localparam int CW     = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          busy;
    logic          holding;
    logic          tc;

    int checks   = 0;
    int failures = 0;

    // Reference model state: plain decimal value and remaining hold cycles.
    int m_value;
    int m_reload;
    int m_hold_left;
    bit m_busy;
    bit m_tc;

    bcd_down_counter #(.DIGITS(DIGITS), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .holding  (holding),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_val(input logic [CW-1:0] v);
        int r = 0;
        int m = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * m;
            m *= 10;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int            x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_value     = 0;
        m_reload    = 0;
        m_hold_left = 0;
        m_busy      = 1'b0;
        m_tc        = 1'b0;
    endtask

    task automatic model_step();
        int c;
        m_tc = 1'b0;
        if (load) begin
            c           = clamp_val(load_val);
            m_value     = c;
            m_reload    = c;
            m_busy      = 1'b1;
            m_hold_left = (c == 0) ? HOLD : 0;
            m_tc        = (c == 0);
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
`ifdef BCD_DCNT_AUTO_RELOAD_EN
                m_value = m_reload;
                if (m_reload == 0) begin
                    m_hold_left = HOLD;
                    m_tc        = 1'b1;
                end
`else
                m_busy = 1'b0;
`endif
            end
        end else if (m_busy && en) begin
            m_value--;
            if (m_value == 0) begin
                m_hold_left = HOLD;
                m_tc        = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " count"},   count,   to_bcd(m_value));
        check({tag, " busy"},    busy,    m_busy);
        check({tag, " holding"}, holding, (m_hold_left > 0));
        check({tag, " tc"},      tc,      m_tc);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // Assert reset between edges and check it takes effect before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, " rst count"},   count,   '0);
        check({tag, " rst busy"},    busy,    1'b0);
        check({tag, " rst holding"}, holding, 1'b0);
        check({tag, " rst tc"},      tc,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        model_reset();
        #3;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full countdown from 12 with en held; load edge also carries en.
        load = 1'b1; load_val = 8'h12; en = 1'b1;
        step("load12");
        check("load12 no dec", count, 8'h12);
        load = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step("down");
            if (i == 3) check("borrow 10->09", count, 8'h09);
        end
        check("first zero tc", tc, 1'b1);
        check("first zero holding", holding, 1'b1);
        step("hold2");
        check("hold2 tc", tc, 1'b0);
        step("hold3");
        check("hold3 holding", holding, 1'b1);
        step("hold exit");
`ifdef BCD_DCNT_AUTO_RELOAD_EN
        check("reload count", count, 8'h12);
        check("reload holding", holding, 1'b0);
`else
        check("oneshot count", count, 8'h00);
        check("oneshot busy", busy, 1'b0);
`endif
        step("after exit");
`ifndef BCD_DCNT_AUTO_RELOAD_EN
        check("idle ignores en", count, 8'h00);
`endif

        // Enable gating.
        load = 1'b1; load_val = 8'h05; en = 1'b0;
        step("load05");
        load = 1'b0;
        en = 1'b1; step("gate1"); check("gate1", count, 8'h04);
        en = 1'b0; step("gate2"); check("gate2", count, 8'h04);
        en = 1'b0; step("gate3"); check("gate3", count, 8'h04);
        en = 1'b1; step("gate4"); check("gate4", count, 8'h03);

        // Clamp and load priority over en.
        load = 1'b1; load_val = 8'h3F; en = 1'b0;
        step("clamp"); check("clamp 3F", count, 8'h39);
        load_val = 8'h05; en = 1'b1;
        step("prio"); check("load beats en", count, 8'h05);

        // Load during second HOLD cycle.
        load_val = 8'h01; en = 1'b1;
        step("load01");
        load = 1'b0;
        step("hold c1");
        step("hold c2");
        load = 1'b1; load_val = 8'h05;
        step("hold load");
        check("hold load holding", holding, 1'b0);
        check("hold load count", count, 8'h05);
        check("hold load busy", busy, 1'b1);

        // Zero load.
        load_val = 8'h00; en = 1'b0;
        step("zero load");
        load = 1'b0;
        check("zero tc", tc, 1'b1);
        check("zero holding", holding, 1'b1);
        step("zero h2");
        step("zero h3");
        check("zero h3 tc", tc, 1'b0);
        step("zero exit");
`ifdef BCD_DCNT_AUTO_RELOAD_EN
        check("zero periodic tc", tc, 1'b1);
        step("zero p2");
        step("zero p3");
        step("zero p4");
        check("zero period 3", tc, 1'b1);
`else
        check("zero oneshot busy", busy, 1'b0);
`endif

        // Reset mid-count.
        load = 1'b1; load_val = 8'h45; en = 1'b1;
        step("load45");
        load = 1'b0;
        for (int i = 0; i < 5; i++) step("count45");
        check("pre-reset count", count, 8'h40);
        async_reset("midcount");
        step("post reset");

        // Randomized stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            load     = ($urandom_range(0, 99) < 6);
            load_val = CW'($urandom);
            if ($urandom_range(0, 3) == 0) load_val = CW'($urandom_range(0, 3));
            en       = ($urandom_range(0, 3) != 0);
            step("rand");
            if ($urandom_range(0, 399) == 0) async_reset("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
